systolic_seq_ctrl: RTL and testbench
====================================

// Module: systolic_seq_ctrl
// PURPOSE
//  Sequencer for an N x N grid of systolic multiply-accumulate units (C = A x B, inner dim K).
//  - Clears the grid by dropping its enable (flag).
//  - Issues skewed per-lane operand reads to the external A-row and B-column buffers.
//  - Holds flag high while wavefronts drain, then pulses a capture strobe for the c_out bank.
//  - Sits between the host/UART command decoder and the systolic grid.
// PARAMETERS
//  N     4    grid dimension: rows = cols = lanes
//  KMAX  16   largest supported inner dimension K
//  KW    5    width of k_len; must satisfy 2^KW > KMAX
// PORTS
//  clk           in   1      system clock, rising edge
//  rst           in   1      asynchronous, active-low reset
//  start         in   1      launch one matrix op; sampled only in IDLE
//  abort         in   1      synchronous cancel of the current op
//  k_len         in   KW     inner dimension K; sampled with start
//  busy          out  1      high from the accepted start until done
//  done          out  1      1-cycle pulse at normal completion
//  err           out  1      1-cycle pulse when a start is rejected
//  array_flag    out  1      grid enable; 0 clears all accumulators
//  lane_valid    out  N      bit i: lane i presents a valid operand this cycle
//  lane_k        out  N*KW   lane i operand index, bits [i*KW +: KW]
//  res_capture   out  1      1-cycle strobe: grid c_out bank holds the final C
// BEHAVIOUR
//  Reset (rst=0, async)
//   - state=IDLE; all outputs 0; internal counters t=0, K=0.
//  FSM: IDLE -> CLEAR -> FEED -> DRAIN -> CAPT -> IDLE
//  IDLE
//   - start && 1<=k_len<=KMAX: latch K=k_len, set busy, go to CLEAR.
//   - start && (k_len==0 || k_len>KMAX): pulse err next cycle, stay IDLE, busy stays 0.
//  CLEAR (1 cycle)
//   - array_flag=0, so the grid zeroes c_reg/c_out.
//   - t<=0; go to FEED.
//  FEED (K+N-1 cycles, t = 0..K+N-2)
//   - array_flag=1.
//   - lane_valid[i] = (t>=i) && (t<i+K).
//   - lane_k[i] = t-i when valid, else 0.
//   - Outputs are registered and change on the edge that advances t.
//   - Invalid lanes: the external buffer must drive 0 operands, so nothing accumulates.
//   - At t=K+N-2: t<=0, go to DRAIN.
//  DRAIN (2N cycles)
//   - array_flag=1, lane_valid=0.
//   - Lets the last operands reach cell (N-1,N-1).
//   - Covers the extra c_reg->c_out register stage.
//  CAPT (1 cycle)
//   - array_flag=1, res_capture=1.
//   - done=1 in the same cycle, busy falls on the next edge.
//   - Go to IDLE.
//   - array_flag drops to 0 in IDLE; the downstream buffer must latch on res_capture.
//  Total latency, start to done: 1 + (K+N-1) + 2N + 1 cycles. N=4, K=4: 17 cycles.
//  start while busy: ignored, no err.
//  abort in any non-IDLE state
//   - Next edge: IDLE, busy=0, array_flag=0, lane_valid=0.
//   - No done, no res_capture.
//   - Takes priority over every same-cycle transition, including CAPT.
//  abort in IDLE: no effect. abort && start together in IDLE: start wins.
//  Counter t is KW+1 bits wide, so K+N-1 never wraps.
//  Reset mid-op: immediate return to the reset state; no pulses emitted.
// CONFIGURATION
//  SYSTOLIC_PERF_EN
//   - Defined: adds port perf_cycles out 16 and a 16-bit counter.
//   - Counter clears on an accepted start and increments every busy cycle.
//   - Saturates at 16'hFFFF and is held after done/abort until the next start.
//   - Reset value 0.
//  Not defined: no port, no counter.
// TESTING
//  1. N=4, k_len=4, start pulse -> busy next cycle; array_flag=0 for exactly 1 cycle;
//     lane_valid walks 0001,0011,0111,1111,1110,1100,1000; done/res_capture at cycle 17.
//  2. k_len=1 -> each lane_valid[i] high exactly 1 cycle at t=i with lane_k[i]=0; done at cycle 14.
//  3. k_len=0 and k_len=17 -> err pulse, busy stays 0, array_flag stays 0.
//  4. abort asserted at t=2 of FEED -> next cycle IDLE, busy=0, lane_valid=0;
//     no done/res_capture; a new start then completes normally.
//  5. start re-pulsed during DRAIN -> ignored; exactly one done.
//     rst low mid-FEED -> all outputs 0 asynchronously.
//  6. SYSTOLIC_PERF_EN, k_len=4 -> perf_cycles=17 after done; abort after 5 busy cycles -> perf_cycles=5.

Source files
------------

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N systolic MAC grid: clears the grid, issues skewed lane reads, drains, strobes capture.
// Optional build macro SYSTOLIC_PERF_EN adds a 16-bit busy-cycle counter on port perf_cycles.
module systolic_seq_ctrl #(
  parameter int unsigned N    = 4,
  parameter int unsigned KMAX = 16,
  parameter int unsigned KW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [KW-1:0]   k_len,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            array_flag,
  output logic [N-1:0]    lane_valid,
  output logic [N*KW-1:0] lane_k,
  output logic            res_capture
`ifdef SYSTOLIC_PERF_EN
  ,
  output logic [15:0]     perf_cycles
`endif
);

  localparam int unsigned TW = KW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_CAPT
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_t, w_t_nxt;
  logic [KW-1:0]   r_k, w_k_nxt;
  logic            w_err_nxt;
  logic            w_k_ok;
  logic            w_feed_last;
  logic            w_drain_last;
  logic [N-1:0]    w_lv_nxt;
  logic [N*KW-1:0] w_lk_nxt;

  logic            r_busy, r_done, r_err, r_flag, r_cap;
  logic [N-1:0]    r_lane_valid;
  logic [N*KW-1:0] r_lane_k;

  assign w_k_ok       = (k_len != '0) && (k_len <= KW'(KMAX));
  assign w_feed_last  = (r_t == ({1'b0, r_k} + TW'(N - 2)));
  assign w_drain_last = (r_t == TW'(2 * N - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    w_k_nxt     = r_k;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_k_ok) begin
            w_k_nxt     = k_len;
            w_state_nxt = S_CLEAR;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        w_t_nxt     = '0;
        w_state_nxt = S_FEED;
      end
      S_FEED: begin
        if (w_feed_last) begin
          w_t_nxt     = '0;
          w_state_nxt = S_DRAIN;
        end else begin
          w_t_nxt = r_t + TW'(1);
        end
      end
      S_DRAIN: begin
        if (w_drain_last) begin
          w_t_nxt     = '0;
          w_state_nxt = S_CAPT;
        end else begin
          w_t_nxt = r_t + TW'(1);
        end
      end
      S_CAPT:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_t_nxt     = '0;
    end
  end

  // Lane outputs are decoded from the next state/t so the registered copies
  // line up with the cycle in which t holds that value.
  always_comb begin
    w_lv_nxt = '0;
    w_lk_nxt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_lv_nxt[i] = (w_state_nxt == S_FEED) && (w_t_nxt >= TW'(i)) &&
                    (w_t_nxt < (TW'(i) + {1'b0, w_k_nxt}));
      w_lk_nxt[i*KW +: KW] = w_lv_nxt[i] ? KW'(w_t_nxt - TW'(i)) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_t          <= '0;
      r_k          <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_flag       <= 1'b0;
      r_cap        <= 1'b0;
      r_lane_valid <= '0;
      r_lane_k     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_t          <= w_t_nxt;
      r_k          <= w_k_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_CAPT);
      r_err        <= w_err_nxt;
      r_flag       <= (w_state_nxt == S_FEED) || (w_state_nxt == S_DRAIN) ||
                      (w_state_nxt == S_CAPT);
      r_cap        <= (w_state_nxt == S_CAPT);
      r_lane_valid <= w_lv_nxt;
      r_lane_k     <= w_lk_nxt;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign array_flag  = r_flag;
  assign res_capture = r_cap;
  assign lane_valid  = r_lane_valid;
  assign lane_k      = r_lane_k;

`ifdef SYSTOLIC_PERF_EN
  logic [15:0] r_perf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf <= '0;
    end else if ((r_state == S_IDLE) && start && w_k_ok) begin
      r_perf <= '0;
    end else if (r_busy && (r_perf != '1)) begin
      r_perf <= r_perf + 16'd1;
    end
  end

  assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl (N=4, KMAX=16, KW=5); checks timing, lane skew, err, abort, reset.
module tb_systolic_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [4:0]  k_len;
  logic        busy, done, err, array_flag, res_capture;
  logic [3:0]  lane_valid;
  logic [19:0] lane_k;
`ifdef SYSTOLIC_PERF_EN
  logic [15:0] perf_cycles;
`endif

  int n_vec;
  int n_bad;

  int          done_cyc, n_done, n_cap, n_clr, n_err;
  logic [3:0]  lv_hist [0:63];
  logic [19:0] lk_hist [0:63];

  systolic_seq_ctrl #(.N(4), .KMAX(16), .KW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .k_len       (k_len),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .array_flag  (array_flag),
    .lane_valid  (lane_valid),
    .lane_k      (lane_k),
    .res_capture (res_capture)
`ifdef SYSTOLIC_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [4:0] k);
    start = 1'b1;
    k_len = k;
    tick();
    start = 1'b0;
  endtask

  // Steps max_cyc cycles, numbering them from 1 after the current point.
  task automatic watch(input int max_cyc);
    done_cyc = 0; n_done = 0; n_cap = 0; n_clr = 0; n_err = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      tick();
      lv_hist[c] = lane_valid;
      lk_hist[c] = lane_k;
      if (done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (res_capture) n_cap++;
      if (err) n_err++;
      if (busy && !array_flag) n_clr++;
    end
  endtask

  initial begin
    logic [3:0] walk [0:6];
    walk[0] = 4'b0001; walk[1] = 4'b0011; walk[2] = 4'b0111; walk[3] = 4'b1111;
    walk[4] = 4'b1110; walk[5] = 4'b1100; walk[6] = 4'b1000;
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    k_len = '0;
    #23;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_flag", {31'd0, array_flag}, 32'd0);
    check("rst_lv", {28'd0, lane_valid}, 32'd0);
    check("rst_lk", {12'd0, lane_k}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
`ifdef SYSTOLIC_PERF_EN
    check("rst_perf", {16'd0, perf_cycles}, 32'd0);
`endif
    rst = 1'b1;
    tick();

    // K=4: full op, cycle 1 = CLEAR
    launch(5'd4);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_clr_flag", {31'd0, array_flag}, 32'd0);
    n_clr = 1;
    watch(17);
    check("t1_clr_cnt", n_clr, 32'd0);
    for (int i = 0; i < 7; i++) check("t1_walk", {28'd0, lv_hist[i+1]}, {28'd0, walk[i]});
    check("t1_drain_lv", {28'd0, lv_hist[8]}, 32'd0);
    check("t1_lk_t0", {12'd0, lk_hist[1]}, 32'h0);
    check("t1_lk_t3", {12'd0, lk_hist[4]}, 32'h443);
    check("t1_lk_t4", {12'd0, lk_hist[5]}, 32'h8860);
    check("t1_lk_t6", {12'd0, lk_hist[7]}, 32'h18000);
    check("t1_done_cyc", done_cyc + 1, 32'd17);
    check("t1_ndone", n_done, 32'd1);
    check("t1_ncap", n_cap, 32'd1);
    check("t1_busy_end", {31'd0, busy}, 32'd0);
    check("t1_flag_end", {31'd0, array_flag}, 32'd0);
`ifdef SYSTOLIC_PERF_EN
    check("t1_perf", {16'd0, perf_cycles}, 32'd17);
`endif

    // K=1: one-cycle diagonal, done at cycle 14
    launch(5'd1);
    watch(20);
    check("t2_lv0", {28'd0, lv_hist[1]}, 32'h1);
    check("t2_lv1", {28'd0, lv_hist[2]}, 32'h2);
    check("t2_lv2", {28'd0, lv_hist[3]}, 32'h4);
    check("t2_lv3", {28'd0, lv_hist[4]}, 32'h8);
    check("t2_lv_after", {28'd0, lv_hist[5]}, 32'h0);
    check("t2_lk", {12'd0, lk_hist[1] | lk_hist[2] | lk_hist[3] | lk_hist[4]}, 32'h0);
    check("t2_done_cyc", done_cyc + 1, 32'd14);
    check("t2_ndone", n_done, 32'd1);

    // K=16: largest legal, done at cycle 1+19+8+1 = 29
    launch(5'd16);
    watch(35);
    check("t2b_lv_t18", {28'd0, lv_hist[19]}, 32'h8);
    check("t2b_lk_t18", {12'd0, lk_hist[19]}, 32'h78000);
    check("t2b_done_cyc", done_cyc + 1, 32'd29);

    // illegal K values
    launch(5'd0);
    check("t3_err0", {31'd0, err}, 32'd1);
    check("t3_busy0", {31'd0, busy}, 32'd0);
    check("t3_flag0", {31'd0, array_flag}, 32'd0);
    tick();
    check("t3_err0_pulse", {31'd0, err}, 32'd0);
    launch(5'd17);
    check("t3_err17", {31'd0, err}, 32'd1);
    check("t3_busy17", {31'd0, busy}, 32'd0);
    tick();
    check("t3_err17_pulse", {31'd0, err}, 32'd0);
    check("t3_flag17", {31'd0, array_flag}, 32'd0);

    // abort at FEED t=2
    launch(5'd4);
    tick(); tick(); tick();
    check("t4_lv_t2", {28'd0, lane_valid}, 32'h7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_lv", {28'd0, lane_valid}, 32'd0);
    check("t4_flag", {31'd0, array_flag}, 32'd0);
`ifdef SYSTOLIC_PERF_EN
    check("t4_perf", {16'd0, perf_cycles}, 32'd4);
`endif
    watch(20);
    check("t4_nodone", n_done, 32'd0);
    check("t4_nocap", n_cap, 32'd0);
    abort = 1'b1;
    launch(5'd4);
    abort = 1'b0;
    check("t4_start_wins", {31'd0, busy}, 32'd1);
    watch(17);
    check("t4_restart_done", done_cyc + 1, 32'd17);

    // start re-pulsed in DRAIN is ignored
    launch(5'd4);
    for (int i = 0; i < 9; i++) tick();
    launch(5'd4);
    watch(15);
    check("t5_done_cyc", done_cyc + 11, 32'd17);
    check("t5_ndone", n_done, 32'd1);
    check("t5_noerr", n_err, 32'd0);

    // async reset mid-FEED
    launch(5'd4);
    tick(); tick(); tick();
    #2;
    rst = 1'b0;
    #1;
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_flag", {31'd0, array_flag}, 32'd0);
    check("t5_rst_lv", {28'd0, lane_valid}, 32'd0);
    check("t5_rst_lk", {12'd0, lane_k}, 32'd0);
    #2;
    rst = 1'b1;
    watch(20);
    check("t5_rst_nodone", n_done, 32'd0);
    check("t5_rst_nocap", n_cap, 32'd0);

`ifdef SYSTOLIC_PERF_EN
    launch(5'd4);
    for (int i = 0; i < 4; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_perf_abort", {16'd0, perf_cycles}, 32'd5);
    tick();
    check("t6_perf_hold", {16'd0, perf_cycles}, 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
